// File: rtl/stage_fetch_pkg.sv
// Shared types and constants for the stage-index ROM fetch controller.
// Holds the FSM encoding, the even/odd word selects and the default stage count.
package stage_fetch_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_START = 3'd1,
      RD_END   = 3'd2,
      WAIT     = 3'd3,
      DONE     = 3'd4
   } state_t;

   localparam logic WORD_START     = 1'b0;
   localparam logic WORD_END       = 1'b1;
   localparam int   DEF_NUM_STAGES = 25;

endpackage

// File: rtl/stage_index_fetch_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first eligible request at or above ptr, wrapping.
// Zero latency; no backpressure, the parent owns and advances the pointer.
module rr_arbiter
   import stage_fetch_pkg::*;
#(
   parameter int  NUM_REQ = 4,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] mask,
   input  logic [ID_W-1:0]    ptr,
   output logic [NUM_REQ-1:0] winner,
   output logic [ID_W-1:0]    winner_id,
   output logic               any
);

   logic [NUM_REQ-1:0] elig;
   logic [ID_W-1:0]    idx;

   assign elig = req & ~mask;

   always_comb begin
      winner    = '0;
      winner_id = '0;
      any       = 1'b0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ptr + ID_W'(k);
         if (!any && elig[idx]) begin
            any         = 1'b1;
            winner_id   = idx;
            winner[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stage_index_fetch_ctrl.sv
// Shares one stage-index ROM among NUM_REQ engines; fetches the start/end word pair per grant.
// Response 3+ROM_LATENCY cycles after arbitration; no queueing, requesters hold req until served.
module stage_index_fetch_ctrl
   import stage_fetch_pkg::*;
#(
   parameter int  NUM_REQ     = 4,
   parameter int  ADDR_WIDTH  = 9,
   parameter int  DATA_WIDTH  = 16,
   parameter int  NUM_STAGES  = DEF_NUM_STAGES,
   parameter int  ROM_LATENCY = 1,
   localparam int ID_W        = $clog2(NUM_REQ),
   localparam int SW          = ADDR_WIDTH - 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req,
   input  logic [NUM_REQ*SW-1:0]   req_stage,
   output logic [NUM_REQ-1:0]      grant,
   output logic [ADDR_WIDTH-1:0]   rom_address,
   output logic                    rom_rden,
   input  logic [DATA_WIDTH-1:0]   rom_q,
   output logic                    resp_valid,
   output logic [ID_W-1:0]         resp_id,
   output logic                    resp_err,
   output logic [DATA_WIDTH-1:0]   index_start,
   output logic [DATA_WIDTH-1:0]   index_end,
   output logic                    busy
);

   // cyc counts cycles since arbitration; the ROM words return at these offsets
   localparam logic [2:0] START_CYC = 3'(1 + ROM_LATENCY);
   localparam logic [2:0] LAST_CYC  = 3'(2 + ROM_LATENCY);

   state_t                  state, state_nxt;
   logic [NUM_REQ-1:0]      mask, win_onehot;
   logic [ID_W-1:0]         win_id, rr_ptr, cur_id;
   logic                    win_vld, win_oor, cur_oor, first_idle, finish;
   logic [SW-1:0]           stage_arr [NUM_REQ];
   logic [SW-1:0]           win_stage, cur_stage;
   logic [2:0]              cyc;
   logic [DATA_WIDTH-1:0]   start_tmp;

   always_comb begin
      for (int i = 0; i < NUM_REQ; i++) stage_arr[i] = req_stage[i*SW +: SW];
   end

   assign win_stage  = stage_arr[win_id];
   assign win_oor    = (int'(win_stage) >= NUM_STAGES);
   assign mask       = first_idle ? (NUM_REQ'(1) << resp_id) : '0;
   assign resp_valid = (state == DONE);
   assign busy       = (state != IDLE);

   // Out-of-range requests spend one WAIT cycle so their error response lines up one cycle after grant
   assign finish = (state == WAIT) && (cur_oor || (cyc == LAST_CYC));

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req       (req),
      .mask      (mask),
      .ptr       (rr_ptr),
      .winner    (win_onehot),
      .winner_id (win_id),
      .any       (win_vld)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:     if (win_vld) state_nxt = win_oor ? WAIT : RD_START;
         RD_START: state_nxt = RD_END;
         RD_END:   state_nxt = WAIT;
         WAIT:     if (finish) state_nxt = DONE;
         DONE:     state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         grant       <= '0;
         rom_rden    <= 1'b0;
         rom_address <= '0;
         rr_ptr      <= '0;
         cur_id      <= '0;
         cur_stage   <= '0;
         cur_oor     <= 1'b0;
         first_idle  <= 1'b0;
         cyc         <= '0;
         start_tmp   <= '0;
         resp_id     <= '0;
         resp_err    <= 1'b0;
         index_start <= '0;
         index_end   <= '0;
      end else begin
         grant      <= '0;
         rom_rden   <= 1'b0;
         first_idle <= (state == DONE);
         if (state == IDLE) begin
            cyc <= 3'd1;
            if (win_vld) begin
               grant     <= win_onehot;
               cur_id    <= win_id;
               cur_stage <= win_stage;
               cur_oor   <= win_oor;
               rr_ptr    <= win_id + 1'b1;
               if (!win_oor) begin
                  rom_rden    <= 1'b1;
                  rom_address <= {win_stage, WORD_START};
               end
            end
         end else begin
            cyc <= cyc + 3'd1;
         end
         if (state == RD_START) begin
            rom_rden    <= 1'b1;
            rom_address <= {cur_stage, WORD_END};
         end
         // Start word is staged so the published response only changes at DONE
         if (state != IDLE && cyc == START_CYC) start_tmp <= rom_q;
         if (finish) begin
            resp_id <= cur_id;
            if (cur_oor) begin
               resp_err    <= 1'b1;
               index_start <= '0;
               index_end   <= '0;
            end else begin
               resp_err    <= (rom_q < start_tmp);
               index_start <= start_tmp;
               index_end   <= rom_q;
            end
         end
      end
   end

endmodule

// File: tb/tb_stage_index_fetch_ctrl.sv
// Randomized requesters against a transaction-schedule reference model of the fetch controller.
module tb_stage_index_fetch_ctrl;

   localparam int NR   = 4;
   localparam int AW   = 9;
   localparam int DW   = 16;
   localparam int NS   = 25;
   localparam int L    = 1;
   localparam int SW   = AW - 1;
   localparam int NCYC = 2500;
   localparam int ASZ  = NCYC + 16;

   logic             clk;
   logic             reset;
   logic [NR-1:0]    req;
   logic [NR*SW-1:0] req_stage;
   logic [NR-1:0]    grant;
   logic [AW-1:0]    rom_address;
   logic             rom_rden;
   logic [DW-1:0]    rom_q;
   logic             resp_valid;
   logic [1:0]       resp_id;
   logic             resp_err;
   logic [DW-1:0]    index_start;
   logic [DW-1:0]    index_end;
   logic             busy;

   stage_index_fetch_ctrl #(
      .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_STAGES(NS), .ROM_LATENCY(L)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_stage(req_stage), .grant(grant),
      .rom_address(rom_address), .rom_rden(rom_rden), .rom_q(rom_q),
      .resp_valid(resp_valid), .resp_id(resp_id), .resp_err(resp_err),
      .index_start(index_start), .index_end(index_end), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [DW-1:0] rom_word(input int a);
      int s;
      s = a / 2;
      if (s == 5) return (a % 2 == 1) ? 16'h00FF : 16'h0100;
      return 16'(16 * s + ((a % 2 == 1) ? 15 : 0));
   endfunction

   // ROM with ROM_LATENCY cycles from registered rden/address to q
   logic [DW-1:0] rom_mem [512];
   logic [DW-1:0] q1, q2;
   initial for (int a = 0; a < 512; a++) rom_mem[a] = rom_word(a);
   always @(posedge clk) begin
      if (rom_rden) q1 <= rom_mem[rom_address];
      q2 <= q1;
   end
   assign rom_q = (L == 1) ? q1 : q2;

   int n_checks = 0;
   int n_errors = 0;
   int cur_t;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cur_t, obs, exp);
      end
   endtask

   // Expected per-cycle schedule
   logic [NR-1:0] exp_grant [ASZ];
   bit            exp_rden  [ASZ];
   bit            exp_busy  [ASZ];
   bit            exp_avld  [ASZ];
   logic [AW-1:0] exp_addr  [ASZ];
   bit            exp_rv    [ASZ];
   bit            exp_rst   [ASZ];
   int            exp_id    [ASZ];
   bit            exp_err   [ASZ];
   logic [DW-1:0] exp_s     [ASZ];
   logic [DW-1:0] exp_e     [ASZ];

   int m_ptr = 0, next_arb = 0, mask_cyc = -1, mask_id = 0, cur_a = -100;
   bit cur_oor = 1'b0;
   logic [AW-1:0] h_addr;
   int h_id;
   bit h_err;
   logic [DW-1:0] h_s, h_e;

   bit waiting [NR];
   int drop_cyc [NR];
   int mid_rst_done = 0;

   task automatic clear_from(input int c0);
      for (int c = c0; c < c0 + 12 && c < ASZ; c++) begin
         exp_grant[c] = '0; exp_rden[c] = 0; exp_busy[c] = 0; exp_avld[c] = 0; exp_addr[c] = '0;
         exp_rv[c] = 0; exp_rst[c] = 0; exp_id[c] = 0; exp_err[c] = 0; exp_s[c] = '0; exp_e[c] = '0;
      end
   endtask

   task automatic drive_inputs(input int t);
      logic [SW-1:0] stg;
      bit rst_mid;
      rst_mid = (t >= 600 * (mid_rst_done + 1)) && (mid_rst_done < 2) && (t == cur_a + 2) && !cur_oor;
      if (rst_mid) mid_rst_done++;
      reset = (t < 3) || rst_mid;
      if (reset) begin
         req = '0;
         for (int i = 0; i < NR; i++) begin
            waiting[i] = 0;
            drop_cyc[i] = -1;
         end
         return;
      end
      for (int i = 0; i < NR; i++) begin
         if (req[i] && drop_cyc[i] == t) begin
            req[i] = 1'b0;
         end else if (!req[i] && !waiting[i] && (t == 3 || $urandom_range(0, 3) == 0)) begin
            if (t == 3) stg = SW'(i);
            else if ($urandom_range(0, 5) == 0) begin
               case ($urandom_range(0, 3))
                  0: stg = 8'd24;
                  1: stg = 8'd25;
                  2: stg = 8'd30;
                  default: stg = 8'd255;
               endcase
            end else stg = SW'($urandom_range(0, NS - 1));
            req_stage[i*SW +: SW] = stg;
            req[i] = 1'b1;
            waiting[i] = 1;
            drop_cyc[i] = -1;
         end
      end
   endtask

   task automatic model_step(input int t);
      logic [NR-1:0] elig;
      logic [SW-1:0] stg;
      int id, rv;
      bit oor;
      if (reset) begin
         clear_from(t + 1);
         exp_rst[t+1] = 1;
         m_ptr = 0; next_arb = t + 1; mask_cyc = -1; cur_a = -100;
         return;
      end
      if (t < next_arb) return;
      elig = req;
      if (t == mask_cyc) elig[mask_id] = 1'b0;
      if (elig == '0) return;
      id = -1;
      for (int k = 0; k < NR; k++) if (id < 0 && elig[(m_ptr + k) % NR]) id = (m_ptr + k) % NR;
      m_ptr = (id + 1) % NR;
      stg = req_stage[id*SW +: SW];
      oor = (int'(stg) >= NS);
      cur_a = t; cur_oor = oor;
      exp_grant[t+1] = 4'b0001 << id;
      rv = oor ? t + 2 : t + 3 + L;
      for (int c = t + 1; c <= rv; c++) exp_busy[c] = 1;
      exp_rv[rv] = 1;
      exp_id[rv] = id;
      if (oor) begin
         exp_err[rv] = 1; exp_s[rv] = '0; exp_e[rv] = '0;
      end else begin
         exp_s[rv] = rom_word(2 * int'(stg));
         exp_e[rv] = rom_word(2 * int'(stg) + 1);
         exp_err[rv] = (exp_e[rv] < exp_s[rv]);
         exp_rden[t+1] = 1; exp_rden[t+2] = 1;
         exp_avld[t+1] = 1; exp_addr[t+1] = {stg, 1'b0};
         exp_avld[t+2] = 1; exp_addr[t+2] = {stg, 1'b1};
      end
      next_arb = rv + 1;
      mask_cyc = rv + 1;
      mask_id = id;
   endtask

   task automatic compare_cycle(input int t);
      if (exp_rst[t]) begin
         h_addr = '0; h_id = 0; h_err = 0; h_s = '0; h_e = '0;
      end
      if (exp_avld[t]) h_addr = exp_addr[t];
      if (exp_rv[t]) begin
         h_id = exp_id[t]; h_err = exp_err[t]; h_s = exp_s[t]; h_e = exp_e[t];
      end
      check("grant",       32'(grant),       32'(exp_grant[t]));
      check("rom_rden",    32'(rom_rden),    32'(exp_rden[t]));
      check("rom_address", 32'(rom_address), 32'(h_addr));
      check("busy",        32'(busy),        32'(exp_busy[t]));
      check("resp_valid",  32'(resp_valid),  32'(exp_rv[t]));
      check("resp_id",     32'(resp_id),     32'(h_id));
      check("resp_err",    32'(resp_err),    32'(h_err));
      check("index_start", 32'(index_start), 32'(h_s));
      check("index_end",   32'(index_end),   32'(h_e));
   endtask

   task automatic observe(input int t);
      for (int i = 0; i < NR; i++)
         if (grant[i] === 1'b1 && $urandom_range(0, 7) == 0) drop_cyc[i] = t + 1;
      if (resp_valid === 1'b1 && !$isunknown(resp_id)) begin
         waiting[resp_id] = 0;
         drop_cyc[resp_id] = t + 1 + $urandom_range(0, 1);
      end
   endtask

   initial begin
      reset = 1'b1;
      req = '0;
      req_stage = '0;
      h_addr = '0; h_id = 0; h_err = 0; h_s = '0; h_e = '0;
      for (int i = 0; i < NR; i++) begin
         waiting[i] = 0;
         drop_cyc[i] = -1;
      end
      clear_from(0);
      for (int c = 0; c < ASZ; c += 12) clear_from(c);
      for (int t = 0; t < NCYC; t++) begin
         @(posedge clk);
         #1;
         cur_t = t;
         drive_inputs(t);
         model_step(t);
         @(negedge clk);
         if (t >= 1) compare_cycle(t);
         observe(t);
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
